// File: rtl/run_ctrl_unit.sv
// Run controller and self-check harness: backdoor-loads memories, runs the core until the PC
// settles or the cycle budget expires, then compares a data-memory window against a signature.
module run_ctrl_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned IMEM_AW     = 8,
  parameter int unsigned DMEM_AW     = 10,
  parameter int unsigned CHK_WORDS   = 4,
  parameter int unsigned CHK_BASE    = 0,
  parameter int unsigned MAX_CYCLES  = 100,
  parameter int unsigned HALT_STABLE = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ld_valid,
  output logic               o_ld_ready,
  input  logic [1:0]         i_ld_target,
  input  logic [DMEM_AW-1:0] i_ld_addr,
  input  logic [XLEN-1:0]    i_ld_data,
  input  logic               i_start,
  input  logic               i_clear,
  output logic               o_core_rstn,
  output logic               o_dbg_sel,
  output logic               o_imem_we,
  output logic [IMEM_AW-1:0] o_imem_addr,
  output logic               o_dmem_we,
  output logic               o_dmem_re,
  output logic [DMEM_AW-1:0] o_dmem_addr,
  output logic [XLEN-1:0]    o_mem_wd,
  input  logic [XLEN-1:0]    i_dmem_rdata,
  input  logic [XLEN-1:0]    i_pc,
  output logic [15:0]        o_cycle_cnt,
  output logic               o_done,
  output logic               o_pass,
  output logic               o_timeout,
  output logic [7:0]         o_fail_idx
);

  localparam int unsigned SigAw = (CHK_WORDS > 1) ? $clog2(CHK_WORDS) : 1;
  localparam int unsigned StAw  = $clog2(HALT_STABLE);

  typedef enum logic [2:0] {StIdle, StRun, StChkRd, StChkCmp, StDone} state_e;

  state_e          r_state, w_state_d;
  logic [15:0]     r_cycle_cnt, w_cycle_cnt_d;
  logic [StAw-1:0] r_stable_cnt, w_stable_cnt_d;
  logic [XLEN-1:0] r_pc_q;
  logic [7:0]      r_idx, w_idx_d;
  logic [7:0]      r_fail_idx, w_fail_idx_d;
  logic            r_done, w_done_d;
  logic            r_pass, w_pass_d;
  logic            r_timeout, w_timeout_d;
  logic            r_core_rstn, r_dbg_sel;
  logic [XLEN-1:0] r_sig [2**SigAw];

  logic w_ld_acc, w_sig_we, w_halt, w_limit, w_last, w_match, w_chk;

  assign w_ld_acc = (r_state == StIdle) && i_ld_valid;
  assign w_sig_we = w_ld_acc && (i_ld_target == 2'd2);
  assign w_halt   = (r_stable_cnt == StAw'(HALT_STABLE - 1));
  assign w_limit  = (r_cycle_cnt == 16'(MAX_CYCLES - 1));
  assign w_last   = (r_idx == 8'(CHK_WORDS - 1));
  assign w_match  = (i_dmem_rdata == r_sig[r_idx[SigAw-1:0]]);
  assign w_chk    = (r_state == StChkRd) || (r_state == StChkCmp);

  // Signature RAM has no reset; it must be loaded before the first check.
  always_ff @(posedge i_clk) begin
    if (w_sig_we) begin
      r_sig[i_ld_addr[SigAw-1:0]] <= i_ld_data;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_cycle_cnt_d  = r_cycle_cnt;
    w_stable_cnt_d = r_stable_cnt;
    w_idx_d        = r_idx;
    w_fail_idx_d   = r_fail_idx;
    w_done_d       = r_done;
    w_pass_d       = r_pass;
    w_timeout_d    = r_timeout;
    unique case (r_state)
      StIdle: begin
        if (i_start && !i_ld_valid) begin
          w_state_d      = StRun;
          w_cycle_cnt_d  = '0;
          w_stable_cnt_d = '0;
          w_idx_d        = '0;
          w_fail_idx_d   = '0;
          w_pass_d       = 1'b0;
          w_timeout_d    = 1'b0;
        end
      end
      StRun: begin
        if (r_cycle_cnt != 16'hFFFF) begin
          w_cycle_cnt_d = r_cycle_cnt + 16'd1;
        end
        w_stable_cnt_d = (i_pc == r_pc_q) ? r_stable_cnt + StAw'(1) : '0;
        // Halt wins over the budget when both hit on the same cycle.
        if (w_halt) begin
          w_state_d   = StChkRd;
          w_timeout_d = 1'b0;
        end else if (w_limit) begin
          w_state_d   = StChkRd;
          w_timeout_d = 1'b1;
        end
      end
      StChkRd: w_state_d = StChkCmp;
      StChkCmp: begin
        if (!w_match) begin
          w_state_d    = StDone;
          w_done_d     = 1'b1;
          w_pass_d     = 1'b0;
          w_fail_idx_d = r_idx;
        end else if (w_last) begin
          w_state_d = StDone;
          w_done_d  = 1'b1;
          w_pass_d  = !r_timeout;
        end else begin
          w_idx_d   = r_idx + 8'd1;
          w_state_d = StChkRd;
        end
      end
      StDone: begin
        if (i_clear) begin
          w_state_d   = StIdle;
          w_done_d    = 1'b0;
          w_pass_d    = 1'b0;
          w_timeout_d = 1'b0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_cycle_cnt  <= '0;
      r_stable_cnt <= '0;
      r_pc_q       <= '0;
      r_idx        <= '0;
      r_fail_idx   <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_timeout    <= 1'b0;
      r_core_rstn  <= 1'b0;
      r_dbg_sel    <= 1'b1;
    end else begin
      r_state      <= w_state_d;
      r_cycle_cnt  <= w_cycle_cnt_d;
      r_stable_cnt <= w_stable_cnt_d;
      r_pc_q       <= i_pc;
      r_idx        <= w_idx_d;
      r_fail_idx   <= w_fail_idx_d;
      r_done       <= w_done_d;
      r_pass       <= w_pass_d;
      r_timeout    <= w_timeout_d;
      r_core_rstn  <= (w_state_d == StRun);
      r_dbg_sel    <= (w_state_d != StRun);
    end
  end

  always_comb begin
    o_ld_ready  = (r_state == StIdle);
    o_imem_we   = w_ld_acc && (i_ld_target == 2'd0);
    o_dmem_we   = w_ld_acc && (i_ld_target == 2'd1);
    o_dmem_re   = (r_state == StChkRd);
    o_imem_addr = i_ld_addr[IMEM_AW-1:0];
    o_dmem_addr = w_chk ? (DMEM_AW'(CHK_BASE) + DMEM_AW'(r_idx)) : i_ld_addr;
    o_mem_wd    = i_ld_data;
  end

  assign o_core_rstn = r_core_rstn;
  assign o_dbg_sel   = r_dbg_sel;
  assign o_cycle_cnt = r_cycle_cnt;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_timeout   = r_timeout;
  assign o_fail_idx  = r_fail_idx;

endmodule

// File: tb/tb_run_ctrl_unit.sv
// Bench for run_ctrl_unit: timeline reference model checked every cycle, directed scenarios and
// randomized load/run/check sequences.
module tb_run_ctrl_unit;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned IMEM_AW     = 8;
  localparam int unsigned DMEM_AW     = 10;
  localparam int unsigned CHK_WORDS   = 4;
  localparam int unsigned CHK_BASE    = 0;
  localparam int unsigned MAX_CYCLES  = 100;
  localparam int unsigned HALT_STABLE = 4;
  localparam int unsigned NPC         = MAX_CYCLES + 2;
  localparam int unsigned DDEPTH      = 2**DMEM_AW;
  localparam int unsigned IDEPTH      = 2**IMEM_AW;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ld_valid, ld_ready, start, clear;
  logic [1:0]         ld_target;
  logic [DMEM_AW-1:0] ld_addr;
  logic [XLEN-1:0]    ld_data;
  logic               core_rstn, dbg_sel, imem_we, dmem_we, dmem_re;
  logic [IMEM_AW-1:0] imem_addr;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [XLEN-1:0]    mem_wd, dmem_rdata, pc;
  logic [15:0]        cycle_cnt;
  logic               done, pass, timeout;
  logic [7:0]         fail_idx;

  run_ctrl_unit #(
    .XLEN(XLEN), .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW), .CHK_WORDS(CHK_WORDS),
    .CHK_BASE(CHK_BASE), .MAX_CYCLES(MAX_CYCLES), .HALT_STABLE(HALT_STABLE)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ld_valid(ld_valid), .o_ld_ready(ld_ready),
    .i_ld_target(ld_target), .i_ld_addr(ld_addr), .i_ld_data(ld_data), .i_start(start),
    .i_clear(clear), .o_core_rstn(core_rstn), .o_dbg_sel(dbg_sel), .o_imem_we(imem_we),
    .o_imem_addr(imem_addr), .o_dmem_we(dmem_we), .o_dmem_re(dmem_re),
    .o_dmem_addr(dmem_addr), .o_mem_wd(mem_wd), .i_dmem_rdata(dmem_rdata), .i_pc(pc),
    .o_cycle_cnt(cycle_cnt), .o_done(done), .o_pass(pass), .o_timeout(timeout),
    .o_fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  // Physical memories driven only through the DUT's backdoor ports.
  logic [XLEN-1:0] imem [IDEPTH];
  logic [XLEN-1:0] dmem [DDEPTH];
  always @(posedge clk) begin
    if (imem_we) imem[imem_addr] <= mem_wd;
    if (dmem_we) dmem[dmem_addr] <= mem_wd;
    if (dmem_re) dmem_rdata <= dmem[dmem_addr];
  end

  // Reference contents as the bench believes they were loaded.
  logic [XLEN-1:0] ref_imem [IDEPTH];
  logic [XLEN-1:0] ref_dmem [DDEPTH];
  logic [XLEN-1:0] ref_sig  [CHK_WORDS];
  logic [XLEN-1:0] pcs      [NPC];

  int checks = 0;
  int errors = 0;
  int n_re   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 busy (run then check timeline), 2 done.
  int m_mode, m_k, m_t, m_nrd, m_fidx, m_cnt;
  bit m_pass, m_to, m_mis;

  task automatic model_start();
    bit same;
    m_t  = MAX_CYCLES - 1;
    m_to = 1'b1;
    for (int t = HALT_STABLE - 1; t < MAX_CYCLES; t++) begin
      same = 1'b1;
      for (int s = t - HALT_STABLE + 1; s <= t; s++) if (pcs[s] != pcs[t]) same = 1'b0;
      if (same) begin
        m_t  = t;
        m_to = 1'b0;
        break;
      end
    end
    m_mis = 1'b0;
    m_nrd = CHK_WORDS;
    for (int i = 0; i < CHK_WORDS; i++) begin
      if (ref_dmem[(CHK_BASE + i) % DDEPTH] != ref_sig[i]) begin
        m_mis  = 1'b1;
        m_fidx = i;
        m_nrd  = i + 1;
        break;
      end
    end
    m_pass = !m_mis && !m_to;
    m_cnt  = m_t + 1;
    m_k    = 0;
    m_mode = 1;
  endtask

  always @(negedge clk) begin : cmp
    int p;
    if (dmem_re) n_re++;
    if (!rst_n) begin
      m_mode = 0;
      m_cnt  = 0;
      chk("rst_core_rstn", core_rstn, 0);
      chk("rst_dbg_sel", dbg_sel, 1);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_cycle_cnt", cycle_cnt, 0);
      chk("rst_fail_idx", fail_idx, 0);
      chk("rst_dmem_re", dmem_re, 0);
    end else begin
      if (m_mode == 0) begin
        chk("idle_ready", ld_ready, 1);
        chk("idle_core_rstn", core_rstn, 0);
        chk("idle_dbg_sel", dbg_sel, 1);
        chk("idle_done", done, 0);
        chk("idle_timeout", timeout, 0);
        chk("idle_cycle_cnt", cycle_cnt, m_cnt);
        chk("idle_dmem_re", dmem_re, 0);
        chk("idle_imem_we", imem_we, ld_valid && ld_target == 2'd0);
        chk("idle_dmem_we", dmem_we, ld_valid && ld_target == 2'd1);
        if (ld_valid && ld_target == 2'd0) begin
          chk("imem_addr", imem_addr, ld_addr % IDEPTH);
          chk("imem_wd", mem_wd, ld_data);
        end
        if (ld_valid && ld_target == 2'd1) begin
          chk("dmem_addr_ld", dmem_addr, ld_addr);
          chk("dmem_wd", mem_wd, ld_data);
        end
      end else begin
        chk("busy_ready", ld_ready, 0);
        chk("busy_imem_we", imem_we, 0);
        chk("busy_dmem_we", dmem_we, 0);
        if (m_mode == 1 && m_k <= m_t) begin
          chk("run_core_rstn", core_rstn, 1);
          chk("run_dbg_sel", dbg_sel, 0);
          chk("run_dmem_re", dmem_re, 0);
          chk("run_cycle_cnt", cycle_cnt, m_k);
          chk("run_timeout", timeout, 0);
          chk("run_done", done, 0);
        end else begin
          chk("chk_core_rstn", core_rstn, 0);
          chk("chk_dbg_sel", dbg_sel, 1);
          chk("chk_cycle_cnt", cycle_cnt, m_cnt);
          chk("chk_timeout", timeout, m_to);
          if (m_mode == 1) begin
            p = m_k - (m_t + 1);
            chk("chk_done", done, 0);
            chk("chk_pass", pass, 0);
            chk("chk_dmem_re", dmem_re, (p % 2) == 0);
            if ((p % 2) == 0) chk("chk_dmem_addr", dmem_addr, (CHK_BASE + p / 2) % DDEPTH);
          end else begin
            chk("done_done", done, 1);
            chk("done_pass", pass, m_pass);
            chk("done_dmem_re", dmem_re, 0);
            if (m_mis) chk("done_fail_idx", fail_idx, m_fidx);
          end
        end
      end
      // Advance the model on this cycle's inputs.
      if (m_mode == 0) begin
        if (ld_valid) begin
          case (ld_target)
            2'd0: ref_imem[ld_addr % IDEPTH] = ld_data;
            2'd1: ref_dmem[ld_addr] = ld_data;
            2'd2: ref_sig[ld_addr % CHK_WORDS] = ld_data;
            default: ;
          endcase
        end else if (start) begin
          model_start();
        end
      end else if (m_mode == 1) begin
        m_k++;
        if (m_k == m_t + 1 + 2 * m_nrd) m_mode = 2;
      end else if (clear) begin
        m_mode = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] tgt, input logic [DMEM_AW-1:0] a,
                      input logic [XLEN-1:0] d);
    ld_valid  = 1'b1;
    ld_target = tgt;
    ld_addr   = a;
    ld_data   = d;
    tick();
    ld_valid = 1'b0;
  endtask

  // Starts a run with the prepared pcs[] and returns cycles from start until done is seen.
  task automatic do_run(output int ncyc);
    bit ok;
    start = 1'b1;
    pc    = pcs[0];
    tick();
    start = 1'b0;
    ok    = 1'b0;
    ncyc  = 0;
    for (int j = 1; j < 1000; j++) begin
      pc = pcs[(j < NPC) ? j : NPC - 1];
      if (done) begin
        ok   = 1'b1;
        ncyc = j;
        break;
      end
      tick();
    end
    if (!ok) chk("run_done_wait", 0, 1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic fill_hold(input logic [XLEN-1:0] v);
    for (int j = 0; j < NPC; j++) pcs[j] = v;
  endtask

  int        ncyc, hold;
  logic [XLEN-1:0] w;

  initial begin
    rst_n = 1'b0; ld_valid = 1'b0; ld_target = '0; ld_addr = '0; ld_data = '0;
    start = 1'b0; clear = 1'b0; pc = '0;
    for (int i = 0; i < DDEPTH; i++) begin dmem[i] = '0; ref_dmem[i] = '0; end
    for (int i = 0; i < IDEPTH; i++) begin imem[i] = '0; ref_imem[i] = '0; end
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reserved target: beat accepted, no strobe.
    ld_valid = 1'b1; ld_target = 2'd3; ld_addr = 10'd7; ld_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t6_ready", ld_ready, 1);
    chk("t6_imem_we", imem_we, 0);
    chk("t6_dmem_we", dmem_we, 0);
    tick();
    ld_valid = 1'b0;

    // Halt with matching signature.
    for (int i = 0; i < 4; i++) load(2'd0, 10'(i), 32'h0000_0013 + 32'(i));
    for (int i = 0; i < 4; i++) load(2'd2, 10'(i), 32'hA5A5_0000 + 32'(i));
    for (int i = 0; i < 4; i++) load(2'd1, 10'(CHK_BASE + i), 32'hA5A5_0000 + 32'(i));
    fill_hold(32'h1C);
    do_run(ncyc);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_timeout", timeout, 0);
    chk("t1_cycle_cnt", cycle_cnt, 4);
    chk("t1_latency", ncyc, 13);
    do_clear();

    // One corrupted word stops the check at its index.
    load(2'd1, 10'(CHK_BASE + 2), 32'h1234_5678);
    fill_hold(32'h1C);
    n_re = 0;
    do_run(ncyc);
    chk("t2_pass", pass, 0);
    chk("t2_fail_idx", fail_idx, 2);
    chk("t2_reads", n_re, 3);
    do_clear();
    load(2'd1, 10'(CHK_BASE + 2), 32'hA5A5_0002);

    // PC never settles: budget expires.
    for (int j = 0; j < NPC; j++) pcs[j] = 32'h100 + 32'(4 * j);
    do_run(ncyc);
    chk("t3_timeout", timeout, 1);
    chk("t3_pass", pass, 0);
    chk("t3_cycle_cnt", cycle_cnt, 100);
    chk("t3_latency", ncyc, 109);
    do_clear();

    // start together with a load beat: beat wins, no run.
    ld_valid = 1'b1; ld_target = 2'd0; ld_addr = 10'd5; ld_data = 32'hCAFE_0005; start = 1'b1;
    tick();
    ld_valid = 1'b0; start = 1'b0;
    chk("t4_ready", ld_ready, 1);
    chk("t4_core_rstn", core_rstn, 0);
    chk("t4_imem", imem[5], 32'hCAFE_0005);
    tick();
    chk("t4_core_rstn2", core_rstn, 0);

    // Reset during the compare phase, then rerun without reloading.
    fill_hold(32'h1C);
    start = 1'b1; pc = pcs[0];
    tick();
    start = 1'b0;
    hold = 0;
    for (int j = 0; j < 200; j++) begin
      if (dmem_re) begin hold = 1; break; end
      tick();
    end
    if (hold == 0) chk("t5_wait_re", 0, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_done", done, 0);
    chk("t5_core_rstn", core_rstn, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    do_run(ncyc);
    chk("t5_pass", pass, 1);
    chk("t5_latency", ncyc, 13);
    do_clear();

    // Randomized load/run/check sequences.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < CHK_WORDS; i++) begin
        w = $urandom;
        case ($urandom_range(0, 3))
          0: load(2'd1, 10'(CHK_BASE + i), w);
          1: load(2'd2, 10'(i + CHK_WORDS * $urandom_range(0, 255)), w);
          2: begin load(2'd2, 10'(i), w); load(2'd1, 10'(CHK_BASE + i), w); end
          default: ;
        endcase
      end
      for (int n = 0; n < 2; n++) load(2'($urandom_range(0, 3)), 10'($urandom_range(4, 1023)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        ld_valid = 1'b1; ld_target = 2'd0; ld_addr = 10'($urandom); ld_data = $urandom;
        start = 1'b1;
        tick();
        ld_valid = 1'b0; start = 1'b0;
      end
      case ($urandom_range(0, 3))
        0: hold = 0;
        1: hold = 30;
        2: hold = 60;
        default: hold = 90;
      endcase
      pcs[0] = $urandom & 32'hFFFF_FFFC;
      for (int j = 1; j < NPC; j++)
        pcs[j] = ($urandom_range(0, 99) < hold) ? pcs[j-1] : pcs[j-1] + 32'd4;
      do_run(ncyc);
      for (int d = 0; d < $urandom_range(0, 3); d++) tick();
      do_clear();
      tick();
    end

    for (int i = 0; i < IDEPTH; i++) chk("imem_contents", imem[i], ref_imem[i]);
    for (int i = 0; i < 16; i++) chk("dmem_contents", dmem[i], ref_dmem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
